// File: rtl/FPU_PACK.sv
// Shared definitions for the two-requester FPU arbiter: widths, FSM encoding,
// FP operation codes and the request/response payload layouts.
package FPU_PACK;

    localparam int unsigned N_REQ        = 2;
    localparam int unsigned DATA_W       = 8;
    localparam int unsigned EXC_W        = 2;
    localparam int unsigned CNT_W        = 3;
    localparam int unsigned WAIT_CYC_DEF = 1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FP_ADD = 2'b00,
        FP_SUB = 2'b01,
        FP_MUL = 2'b10,
        FP_DIV = 2'b11
    } fp_op_t;

    typedef struct packed {
        logic [DATA_W-1:0] op_a;
        logic [DATA_W-1:0] op_b;
        fp_op_t            op;
        logic              rm;
    } req_t;

    typedef struct packed {
        logic [DATA_W-1:0] result;
        logic              is_exc;
        logic [EXC_W-1:0]  exc;
    } rsp_t;

    // One-hot response-valid vector for a requester index.
    function automatic logic [N_REQ-1:0] idx2onehot(input logic idx);
        return idx ? N_REQ'(2'b10) : N_REQ'(2'b01);
    endfunction

endpackage

// File: rtl/fpu8_arbiter_if.sv
// Requester-side handshake bus plus FPU-side operand/result bus of the arbiter.
interface fpu8_arbiter_if;

    logic [FPU_PACK::N_REQ-1:0]          REQ_VALID;
    logic [FPU_PACK::N_REQ-1:0]          REQ_READY;
    logic [2*FPU_PACK::DATA_W-1:0]       REQ_OP_A;
    logic [2*FPU_PACK::DATA_W-1:0]       REQ_OP_B;
    logic [3:0]                          REQ_OPERATION;
    logic [FPU_PACK::N_REQ-1:0]          REQ_ROUND_MODE;
    logic [FPU_PACK::N_REQ-1:0]          RSP_VALID;
    logic [FPU_PACK::N_REQ-1:0]          RSP_READY;
    logic [FPU_PACK::DATA_W-1:0]         RSP_RESULT;
    logic                                RSP_IS_EXCEPTION;
    logic [FPU_PACK::EXC_W-1:0]          RSP_EXCEPTION;

    logic                                FP_Start;
    logic [FPU_PACK::DATA_W-1:0]         FPU_OP_A;
    logic [FPU_PACK::DATA_W-1:0]         FPU_OP_B;
    logic [1:0]                          FP_OPERATION;
    logic                                FP_ROUND_MODE;
    logic [FPU_PACK::DATA_W-1:0]         OP_RESULT;
    logic                                OP_IS_EXCEPTION;
    logic [FPU_PACK::EXC_W-1:0]          FP_Exception;

    // Arbiter side.
    modport slave (
        input  REQ_VALID, REQ_OP_A, REQ_OP_B, REQ_OPERATION, REQ_ROUND_MODE, RSP_READY,
        input  OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        output REQ_READY, RSP_VALID, RSP_RESULT, RSP_IS_EXCEPTION, RSP_EXCEPTION,
        output FP_Start, FPU_OP_A, FPU_OP_B, FP_OPERATION, FP_ROUND_MODE
    );

    // Requesters together with the external FPU.
    modport master (
        output REQ_VALID, REQ_OP_A, REQ_OP_B, REQ_OPERATION, REQ_ROUND_MODE, RSP_READY,
        output OP_RESULT, OP_IS_EXCEPTION, FP_Exception,
        input  REQ_READY, RSP_VALID, RSP_RESULT, RSP_IS_EXCEPTION, RSP_EXCEPTION,
        input  FP_Start, FPU_OP_A, FPU_OP_B, FP_OPERATION, FP_ROUND_MODE
    );

endinterface

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one
// that did not win last.
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_last,
    output logic [1:0] o_grant_c
);

    always_comb begin
        o_grant_c = 2'b00;
        case (i_valid)
            2'b01:   o_grant_c = 2'b01;
            2'b10:   o_grant_c = 2'b10;
            2'b11:   o_grant_c = i_last ? 2'b01 : 2'b10;
            default: o_grant_c = 2'b00;
        endcase
    end

endmodule

// File: rtl/fpu8_arbiter.sv
// Shares one external 8-bit FPU between two requesters: accept, hold FP_Start
// for WAIT_CYC cycles, capture the result and return it to the owner.
module fpu8_arbiter
    import FPU_PACK::*;
#(
    parameter int unsigned WAIT_CYC = WAIT_CYC_DEF
) (
    input  logic           CLK,
    input  logic           RST,
    fpu8_arbiter_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WAIT_CYC - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    logic                 r_last;
    logic                 r_owner;
    logic [CNT_W-1:0]     r_cnt;
    req_t                 r_req;
    rsp_t                 r_rsp;
    logic                 r_fp_start;
    logic [N_REQ-1:0]     r_rsp_valid;

    logic [N_REQ-1:0]     w_arb_valid;
    logic [N_REQ-1:0]     w_grant;
    logic                 w_accept;
    logic                 w_win;
    logic                 w_last_cyc;
    logic                 w_rsp_hs;
    req_t                 w_win_req;

    // Only arbitrate while idle and out of reset; grant doubles as REQ_READY.
    assign w_arb_valid = (r_state == ST_IDLE && !RST) ? bus.REQ_VALID : '0;

    rr_arbiter2 u_rr (
        .i_valid   (w_arb_valid),
        .i_last    (r_last),
        .o_grant_c (w_grant)
    );

    assign w_accept   = |w_grant;
    assign w_win      = w_grant[1];
    assign w_last_cyc = (r_cnt == LAST_CNT);
    assign w_rsp_hs   = (r_state == ST_RESP) && bus.RSP_READY[r_owner];

    always_comb begin
        w_win_req.op_a = w_win ? bus.REQ_OP_A[15:8] : bus.REQ_OP_A[7:0];
        w_win_req.op_b = w_win ? bus.REQ_OP_B[15:8] : bus.REQ_OP_B[7:0];
        w_win_req.op   = fp_op_t'(w_win ? bus.REQ_OPERATION[3:2] : bus.REQ_OPERATION[1:0]);
        w_win_req.rm   = bus.REQ_ROUND_MODE[w_win];
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:  if (w_accept)   w_state_nxt = ST_ISSUE;
            ST_ISSUE: if (w_last_cyc) w_state_nxt = ST_RESP;
            ST_RESP:  if (w_rsp_hs)   w_state_nxt = ST_IDLE;
            default:                  w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Datapath: latch on accept, count Start cycles, capture, release on handshake.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_last      <= 1'b1;
            r_owner     <= 1'b0;
            r_cnt       <= '0;
            r_req       <= '0;
            r_rsp       <= '0;
            r_fp_start  <= 1'b0;
            r_rsp_valid <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_last     <= w_win;
                        r_owner    <= w_win;
                        r_req      <= w_win_req;
                        r_cnt      <= '0;
                        r_fp_start <= 1'b1;
                    end
                end
                ST_ISSUE: begin
                    if (w_last_cyc) begin
                        r_rsp.result <= bus.OP_RESULT;
                        r_rsp.is_exc <= bus.OP_IS_EXCEPTION;
                        r_rsp.exc    <= bus.FP_Exception;
                        r_fp_start   <= 1'b0;
                        r_rsp_valid  <= idx2onehot(r_owner);
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_rsp_hs) begin
                        r_rsp_valid <= '0;
                    end
                end
                default: begin
                    r_fp_start  <= 1'b0;
                    r_rsp_valid <= '0;
                end
            endcase
        end
    end

    assign bus.REQ_READY        = w_grant;
    assign bus.RSP_VALID        = r_rsp_valid;
    assign bus.RSP_RESULT       = r_rsp.result;
    assign bus.RSP_IS_EXCEPTION = r_rsp.is_exc;
    assign bus.RSP_EXCEPTION    = r_rsp.exc;
    assign bus.FP_Start         = r_fp_start;
    assign bus.FPU_OP_A         = r_req.op_a;
    assign bus.FPU_OP_B         = r_req.op_b;
    assign bus.FP_OPERATION     = r_req.op;
    assign bus.FP_ROUND_MODE    = r_req.rm;

endmodule

// File: tb/tb_fpu8_arbiter.sv
// Bench for fpu8_arbiter: transaction-level reference model on a WAIT_CYC=1
// instance, plus directed WAIT_CYC=3 and WAIT_CYC=4 scenarios.
module tb_fpu8_arbiter;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;
    int   n_fail;

    // Reference-model state: which requester won the previous accept.
    logic m_last;

    logic [7:0] pa  [2];
    logic [7:0] pb  [2];
    logic [1:0] pop [2];
    logic       prm [2];
    logic       ovr_en;
    logic [7:0] ovr_res;
    logic [7:0] st3_cnt;

    fpu8_arbiter_if b1 ();
    fpu8_arbiter_if b3 ();
    fpu8_arbiter_if b4 ();

    fpu8_arbiter #(.WAIT_CYC(1)) u_dut1 (.CLK(clk), .RST(rst), .bus(b1));
    fpu8_arbiter #(.WAIT_CYC(3)) u_dut3 (.CLK(clk), .RST(rst), .bus(b3));
    fpu8_arbiter #(.WAIT_CYC(4)) u_dut4 (.CLK(clk), .RST(rst), .bus(b4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Toy FPU behaviour used both as the stub and to predict responses.
    function automatic logic [7:0] ref_res(input logic [7:0] a, input logic [7:0] b,
                                           input logic [1:0] op, input logic rm);
        logic [7:0] r;
        case (op)
            2'b00:   r = a + b;
            2'b01:   r = a - b;
            2'b10:   r = 8'(a * b);
            default: r = a ^ b;
        endcase
        return r + 8'(rm);
    endfunction

    function automatic logic ref_isx(input logic [7:0] a);
        return a == 8'hFF;
    endfunction

    function automatic logic [1:0] ref_exc(input logic [7:0] a, input logic [7:0] b);
        return {a[7], b[0]};
    endfunction

    function automatic logic [1:0] exp_grant(input logic [1:0] mask, input logic last);
        if (mask == 2'b11) return last ? 2'b01 : 2'b10;
        return mask;
    endfunction

    assign b1.REQ_OP_A        = {pa[1], pa[0]};
    assign b1.REQ_OP_B        = {pb[1], pb[0]};
    assign b1.REQ_OPERATION   = {pop[1], pop[0]};
    assign b1.REQ_ROUND_MODE  = {prm[1], prm[0]};
    assign b1.OP_RESULT       = ovr_en ? ovr_res
                              : ref_res(b1.FPU_OP_A, b1.FPU_OP_B, b1.FP_OPERATION, b1.FP_ROUND_MODE);
    assign b1.OP_IS_EXCEPTION = ref_isx(b1.FPU_OP_A);
    assign b1.FP_Exception    = ref_exc(b1.FPU_OP_A, b1.FPU_OP_B);

    // WAIT_CYC=3 stub: result steps 11,22,33 across consecutive Start cycles.
    always @(posedge clk) st3_cnt <= b3.FP_Start ? st3_cnt + 8'd1 : 8'd0;
    assign b3.OP_RESULT       = 8'(8'h11 * (st3_cnt + 8'd1));
    assign b3.OP_IS_EXCEPTION = 1'b0;
    assign b3.FP_Exception    = 2'b00;

    assign b4.OP_RESULT       = 8'h5A;
    assign b4.OP_IS_EXCEPTION = 1'b0;
    assign b4.FP_Exception    = 2'b00;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transaction on the WAIT_CYC=1 instance, starting just after a negedge.
    task automatic do_op(input logic [1:0] vmask, input int bp, input logic [1:0] wait_mask,
                         output int win);
        logic [1:0] g;
        logic [1:0] nonown;
        logic [7:0] ea, eb, er;
        logic [1:0] eo, ex;
        logic       erm, eix;
        b1.REQ_VALID = vmask;
        b1.RSP_READY = 2'b00;
        #1;
        g   = exp_grant(vmask, m_last);
        win = g[1] ? 1 : 0;
        chk("grant", 64'(b1.REQ_READY), 64'(g));
        ea  = pa[win];
        eb  = pb[win];
        eo  = pop[win];
        erm = prm[win];
        er  = ovr_en ? ovr_res : ref_res(ea, eb, eo, erm);
        eix = ref_isx(ea);
        ex  = ref_exc(ea, eb);
        m_last = g[1];
        @(posedge clk);
        @(negedge clk);
        b1.REQ_VALID = wait_mask;
        for (int r = 0; r < 2; r++) begin
            pa[r]  = 8'($urandom);
            pb[r]  = 8'($urandom);
            pop[r] = 2'($urandom);
            prm[r] = 1'($urandom);
        end
        #1;
        chk("start_hi", 64'(b1.FP_Start), 64'd1);
        chk("fpu_ops", 64'({b1.FPU_OP_A, b1.FPU_OP_B, b1.FP_OPERATION, b1.FP_ROUND_MODE}),
            64'({ea, eb, eo, erm}));
        chk("ready_issue", 64'(b1.REQ_READY), 64'd0);
        @(negedge clk);
        #1;
        chk("start_lo", 64'(b1.FP_Start), 64'd0);
        chk("rsp_valid", 64'(b1.RSP_VALID), 64'(g));
        chk("rsp_data", 64'({b1.RSP_RESULT, b1.RSP_IS_EXCEPTION, b1.RSP_EXCEPTION}),
            64'({er, eix, ex}));
        nonown = g ^ 2'b11;
        for (int c = 0; c < bp; c++) begin
            b1.RSP_READY = nonown & 2'($urandom);
            @(negedge clk);
            #1;
            chk("bp_valid", 64'(b1.RSP_VALID), 64'(g));
            chk("bp_data", 64'({b1.RSP_RESULT, b1.RSP_IS_EXCEPTION, b1.RSP_EXCEPTION}),
                64'({er, eix, ex}));
            chk("bp_ready", 64'(b1.REQ_READY), 64'd0);
        end
        b1.RSP_READY = g | (nonown & 2'($urandom));
        #1;
        chk("hs_ready", 64'(b1.REQ_READY), 64'd0);
        @(negedge clk);
        b1.RSP_READY = 2'b00;
        #1;
        chk("post_valid", 64'(b1.RSP_VALID), 64'd0);
        chk("post_hold", 64'({b1.RSP_RESULT, b1.RSP_IS_EXCEPTION, b1.RSP_EXCEPTION}),
            64'({er, eix, ex}));
    endtask

    initial begin
        int wins [4];
        int w;
        int cnt;
        int rsp_cyc;
        logic [7:0] res3;
        logic [1:0] rv3;
        logic saw;

        n_pass = 0; n_total = 0; n_fail = 0;
        m_last = 1'b1;
        ovr_en = 1'b0; ovr_res = 8'h00;
        rst = 1'b1;
        for (int r = 0; r < 2; r++) begin
            pa[r] = 8'h00; pb[r] = 8'h00; pop[r] = 2'b00; prm[r] = 1'b0;
        end
        b1.REQ_VALID = 2'b00; b1.RSP_READY = 2'b00;
        b3.REQ_VALID = 2'b00; b3.RSP_READY = 2'b00;
        b3.REQ_OP_A = 16'h0201; b3.REQ_OP_B = 16'h0403;
        b3.REQ_OPERATION = 4'h0; b3.REQ_ROUND_MODE = 2'b00;
        b4.REQ_VALID = 2'b00; b4.RSP_READY = 2'b00;
        b4.REQ_OP_A = 16'h1234; b4.REQ_OP_B = 16'h5678;
        b4.REQ_OPERATION = 4'h6; b4.REQ_ROUND_MODE = 2'b01;

        // Reset: all outputs zero.
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out1", 64'({b1.REQ_READY, b1.RSP_VALID, b1.RSP_RESULT, b1.RSP_IS_EXCEPTION,
            b1.RSP_EXCEPTION, b1.FP_Start, b1.FPU_OP_A, b1.FPU_OP_B, b1.FP_OPERATION,
            b1.FP_ROUND_MODE}), 64'd0);
        chk("rst_out3", 64'({b3.REQ_READY, b3.RSP_VALID, b3.RSP_RESULT, b3.FP_Start,
            b3.FPU_OP_A, b3.FPU_OP_B}), 64'd0);
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Both requesters continuously valid: strict alternation from requester 0.
        for (int i = 0; i < 4; i++) begin
            do_op(2'b11, 0, 2'b11, wins[i]);
        end
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("order%0d", i), 64'(wins[i]), 64'(i % 2));
        end

        // Single request with a forced FPU result.
        pa[0] = 8'h38; pb[0] = 8'h40; pop[0] = 2'b00; prm[0] = 1'b0;
        ovr_en = 1'b1; ovr_res = 8'h44;
        do_op(2'b01, 0, 2'b00, w);
        chk("single_res", 64'(b1.RSP_RESULT), 64'h44);
        chk("single_opa", 64'({b1.FPU_OP_A, b1.FPU_OP_B}), 64'h3840);
        ovr_en = 1'b0;

        // Owner stalls 5 cycles while requester 1 waits; then requester 1 is served.
        do_op(2'b01, 5, 2'b10, w);
        chk("stall_win0", 64'(w), 64'd0);
        pa[1] = 8'hFF; pb[1] = 8'h00; pop[1] = 2'b11; prm[1] = 1'b0;
        do_op(2'b10, 0, 2'b00, w);
        chk("exc_win1", 64'(w), 64'd1);
        chk("exc_fields", 64'({b1.RSP_IS_EXCEPTION, b1.RSP_EXCEPTION}), 64'({1'b1, 2'b10}));

        // Randomised traffic.
        for (int i = 0; i < 25; i++) begin
            do_op(2'($urandom_range(1, 3)), $urandom_range(0, 3), 2'($urandom_range(0, 3)), w);
        end

        // WAIT_CYC=3: Start held three cycles, result sampled on the last one.
        b3.REQ_VALID = 2'b01;
        #1;
        chk("w3_grant", 64'(b3.REQ_READY), 64'd1);
        @(posedge clk);
        @(negedge clk);
        b3.REQ_VALID = 2'b00;
        cnt = 0; rsp_cyc = -1; res3 = 8'h00; rv3 = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            #1;
            if (b3.FP_Start === 1'b1) cnt++;
            if (b3.RSP_VALID !== 2'b00 && rsp_cyc < 0) begin
                rsp_cyc = i; res3 = b3.RSP_RESULT; rv3 = b3.RSP_VALID;
            end
            @(negedge clk);
        end
        chk("w3_start_cnt", 64'(cnt), 64'd3);
        chk("w3_rsp_cyc", 64'(rsp_cyc), 64'd4);
        chk("w3_rsp_valid", 64'(rv3), 64'd1);
        chk("w3_result", 64'(res3), 64'h33);
        b3.RSP_READY = 2'b01;
        @(negedge clk);
        b3.RSP_READY = 2'b00;
        #1;
        chk("w3_release", 64'(b3.RSP_VALID), 64'd0);

        // WAIT_CYC=4: reset mid-issue abandons the transaction.
        b4.REQ_VALID = 2'b01;
        @(posedge clk);
        @(negedge clk);
        b4.REQ_VALID = 2'b00;
        #1;
        chk("w4_start1", 64'(b4.FP_Start), 64'd1);
        @(negedge clk);
        #1;
        chk("w4_start2", 64'(b4.FP_Start), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("w4_rst_out", 64'({b4.REQ_READY, b4.RSP_VALID, b4.RSP_RESULT, b4.RSP_IS_EXCEPTION,
            b4.RSP_EXCEPTION, b4.FP_Start, b4.FPU_OP_A, b4.FPU_OP_B, b4.FP_OPERATION,
            b4.FP_ROUND_MODE}), 64'd0);
        rst = 1'b0;
        saw = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            #1;
            if (b4.RSP_VALID !== 2'b00 || b4.FP_Start !== 1'b0) saw = 1'b1;
        end
        chk("w4_no_rsp", 64'(saw), 64'd0);
        b4.REQ_VALID = 2'b11;
        #1;
        chk("w4_tie_after_rst", 64'(b4.REQ_READY), 64'd1);
        @(negedge clk);
        b4.REQ_VALID = 2'b00;

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/fpu8_arbiter.md
FPU8_ARBITER -- requirements
Module: fpu8_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYC, default 1, number of cycles FP_Start is held before result capture (legal 1..7).
REQ-002 SHALL have port CLK  in  1  rising-edge clock.
REQ-003 SHALL have port RST  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port REQ_VALID  in  2  request valid; bit i is requester i.
REQ-005 SHALL have port REQ_READY  out  2  accept; a transfer occurs when REQ_VALID[i] and REQ_READY[i] are both high at a rising edge.
REQ-006 SHALL have ports REQ_OP_A, REQ_OP_B  in  16  operands; requester i uses bits [8i+7:8i].
REQ-007 SHALL have ports REQ_OPERATION  in  4 (2 bits per requester) and REQ_ROUND_MODE  in  2 (1 bit per requester).
REQ-008 SHALL have ports RSP_VALID  out  2; RSP_READY  in  2; RSP_RESULT  out  8; RSP_IS_EXCEPTION  out  1; RSP_EXCEPTION  out  2.
REQ-009 SHALL have FPU-side ports FP_Start  out  1; FPU_OP_A, FPU_OP_B  out  8; FP_OPERATION  out  2; FP_ROUND_MODE  out  1; OP_RESULT  in  8; OP_IS_EXCEPTION  in  1; FP_Exception  in  2.

Function
REQ-010 SHALL implement FSM states IDLE, ISSUE and RESP; IDLE is entered from reset.
REQ-011 In IDLE, REQ_READY SHALL be one-hot on the arbitration winner when any REQ_VALID bit is set, and 2'b00 otherwise; REQ_READY SHALL be 2'b00 in ISSUE and RESP.
REQ-012 Arbitration SHALL be round-robin using register LAST: a lone valid requester wins; when both are valid, the requester != LAST wins; LAST updates to the winner on accept.
REQ-013 On accept, the block SHALL latch the winner's operands, operation, round mode and index (OWNER), clear the wait counter, and enter ISSUE.
REQ-014 FPU_OP_A, FPU_OP_B, FP_OPERATION and FP_ROUND_MODE SHALL be driven from the latched registers in all states and SHALL change only on accept.
REQ-015 In ISSUE, FP_Start SHALL be 1 for exactly WAIT_CYC consecutive cycles; on the last of these cycles the block SHALL capture OP_RESULT, OP_IS_EXCEPTION and FP_Exception and enter RESP.
REQ-016 Latency: for an accept at edge k, FP_Start SHALL be high in cycles k+1..k+WAIT_CYC and RSP_VALID[OWNER] SHALL rise in cycle k+WAIT_CYC+1.
REQ-017 In RESP, RSP_VALID SHALL be one-hot on OWNER, and the captured data SHALL be held stable until RSP_READY[OWNER]=1; RSP_READY of the non-owner bit SHALL be ignored.
REQ-018 On the RESP handshake, the block SHALL return to IDLE; a new request SHALL NOT be accepted in the same cycle, giving a minimum period of WAIT_CYC+2 cycles per operation.
REQ-019 RSP_RESULT, RSP_IS_EXCEPTION and RSP_EXCEPTION SHALL retain the last captured values when RSP_VALID=0.
REQ-020 Deassertion of REQ_VALID without a handshake SHALL have no effect on state.

Reset
REQ-021 On RST=1 at a rising edge, the block SHALL enter IDLE, set LAST=1 (requester 0 wins the first tie), clear the counter and OWNER, and drive all outputs to 0.
REQ-022 Reset SHALL take precedence over every other event; reset during ISSUE or RESP SHALL abandon the transaction, with no response emitted.

Structure
REQ-023 Shared package FPU_PACK SHALL hold the FSM state encoding, the 2-bit FP operation codes, the exception-code width and the WAIT_CYC default.
REQ-024 The 2-way round-robin picker SHALL be sub-module rr_arbiter2; the FPU itself SHALL be instantiated outside this block.

Verification
REQ-025 Single request, WAIT_CYC=1: req0 with A=8'h38, B=8'h40, op=2'b00, rm=0, FPU model returning 8'h44 -> FP_Start high 1 cycle with FPU_OP_A=8'h38, FPU_OP_B=8'h40; RSP_VALID=2'b01 and RSP_RESULT=8'h44 in cycle k+2.
REQ-026 Both requesters valid continuously after reset, four operations -> grant order 0,1,0,1, and REQ_READY is never 2'b11.
REQ-027 RSP_READY[0]=0 for 5 cycles while req1 is valid -> RSP_VALID=2'b01 with stable data, REQ_READY=2'b00; req1 is granted only in the cycle after the req0 handshake.
REQ-028 FPU model returning OP_IS_EXCEPTION=1 and FP_Exception=2'b10 for req1 -> RSP_VALID=2'b10, RSP_IS_EXCEPTION=1, RSP_EXCEPTION=2'b10.
REQ-029 WAIT_CYC=3 with OP_RESULT changing 8'h11->8'h22->8'h33 across the Start cycles -> FP_Start high exactly 3 cycles and RSP_RESULT=8'h33.
REQ-030 WAIT_CYC=4 with RST asserted in the 2nd FP_Start cycle -> next cycle all outputs are 0 and no RSP_VALID occurs; with both requesters then valid, req0 is granted first.
